mux_arbiter_rr: RTL and testbench
=================================

Name: mux_arbiter_rr

Overview:
Round-robin arbiter that shares one 2:1 data mux between two requesters. It sequences the mux select line and registers the selected data. Each requester raises a request, receives a grant, and keeps its request high for as long as it needs the path. A hold limit bounds how long one owner can keep the mux while the other requester waits.

Parameters:
W, 8, data width of each mux input and of the output.
MAX_HOLD, 8, maximum cycles an owner keeps its grant while the other request is pending. Must be 2..15.
CW, 4, width of the hold counter. Must satisfy 2**CW > MAX_HOLD.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  reset, asynchronous, active-low.
req0  input  1  request from requester 0; held high while it uses the path.
req1  input  1  request from requester 1; same rules as req0.
d0  input  W  data from requester 0 (mux input i0).
d1  input  W  data from requester 1 (mux input i1).
gnt0  output  1  registered grant to requester 0.
gnt1  output  1  registered grant to requester 1.
s  output  1  mux select: 0 selects d0, 1 selects d1.
z  output  W  registered mux output.
z_vld  output  1  z holds data from the current owner.
lock  input  1  only present when MUX_ARB_LOCK_EN is defined; see Optional Feature.

Behaviour:
- One clock, clk. Reset is asynchronous and active-low on rst_n; all state clears immediately when rst_n falls.
- Reset values:
  - state=IDLE, gnt0=0, gnt1=0, s=0.
  - last=1, so requester 0 wins the first tie.
  - hold_cnt=0, z=0, z_vld=0.
- States: IDLE, G0, G1. gnt0 is high only in G0; gnt1 is high only in G1. Grants are never high together.
- IDLE:
  - req0 & req1: go to G1 if last=0, else G0.
  - Only one request high: go to that requester's state.
  - No request: stay in IDLE.
  - Grant latency: 1 clock from the request being sampled.
- G0 (G1 is symmetric):
  - req0=0 & req1=1: go directly to G1, with no IDLE bubble.
  - req0=0 & req1=0: go to IDLE.
  - req0=1 & req1=1 & hold_cnt==MAX_HOLD-1: forced switch to G1 (fairness preemption).
  - Otherwise stay in G0.
- hold_cnt:
  - Increments each cycle in G0/G1 while the other request is high.
  - Clears on every state change and whenever the other request is low.
  - Saturates at MAX_HOLD-1.
- last: updated to the owner's index on every entry into G0 or G1.
- s:
  - 0 in G0, 1 in G1.
  - In IDLE, s keeps its last value, so the mux output does not glitch.
- Data path:
  - z <= s ? d1 : d0 every cycle.
  - z_vld <= gnt0 | gnt1.
  - z and z_vld therefore lag the grant/select by one cycle.
- A request that drops and re-rises in the same cycle as a grant change is handled as a new request. No grant is granted to a low request.
- Reset mid-grant: grant is removed immediately (asynchronous); z_vld=0 on the next read.

Optional Feature:
MUX_ARB_LOCK_EN
- Defined: the lock port exists. While the current owner holds lock=1, preemption is suppressed and hold_cnt is frozen. Release still happens on req drop.
- Undefined: no lock port; preemption always applies at MAX_HOLD.

Decomposition:
- Package mux_arb_pkg:
  - state typedef: IDLE=2'b00, G0=2'b01, G1=2'b10.
  - default constants for MAX_HOLD and CW.
- One sub-module, mux_reg_stage: a W-bit 2:1 mux followed by an output register, with z_vld and asynchronous active-low reset.
- The arbiter FSM stays in the top module.

Test Plan:
- Reset then req0=1 alone → gnt0=1 and s=0 at the next edge; z=d0 (e.g. 8'hA5) one cycle later with z_vld=1.
- req0=req1=1 from IDLE after reset → gnt0 first. Drop req0 → gnt1=1 on the next edge with no IDLE cycle; s=1.
- req0 and req1 held high, MAX_HOLD=8 → gnt0 for 8 cycles, then gnt1 for 8, alternating indefinitely.
- MUX_ARB_LOCK_EN with lock=1 held by owner 0 → gnt0 stays high for 20+ cycles despite req1=1. lock=0 → switch to gnt1 after MAX_HOLD cycles.
- Drop all requests → IDLE; s keeps its last value (1); z_vld=0 one cycle later.
- Assert rst_n=0 mid-G1 → gnt1=0, s=0, z=0 immediately, without waiting for clk.

Source files
------------

// File: rtl/mux_arb_pkg.sv
// Shared types and defaults for the round-robin mux arbiter.
// Holds the FSM state encoding and the pure next-state decision function.
package mux_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      G0   = 2'b01,
      G1   = 2'b10
   } state_t;

   localparam int MAX_HOLD_DEF = 8;
   localparam int CW_DEF       = 4;

   // last=1 means requester 1 owned most recently, so requester 0 wins a tie
   function automatic state_t next_state(input state_t st,
                                         input logic   r0,
                                         input logic   r1,
                                         input logic   last,
                                         input logic   preempt);
      state_t nxt;
      nxt = st;
      case (st)
         IDLE: begin
            if (r0 && r1)  nxt = last ? G0 : G1;
            else if (r0)   nxt = G0;
            else if (r1)   nxt = G1;
         end
         G0: begin
            if (!r0)          nxt = r1 ? G1 : IDLE;
            else if (preempt) nxt = G1;
         end
         G1: begin
            if (!r1)          nxt = r0 ? G0 : IDLE;
            else if (preempt) nxt = G0;
         end
         default: nxt = IDLE;
      endcase
      return nxt;
   endfunction

endpackage

// File: rtl/mux_reg_stage.sv
// W-bit 2:1 mux followed by the output register and its valid flag.
module mux_reg_stage #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         sel,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         vld,
   output logic [W-1:0] z,
   output logic         z_vld
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         z     <= '0;
         z_vld <= 1'b0;
      end else begin
         // NOTE: non-blocking so every register samples pre-edge values.
         z     <= sel ? b : a;
         z_vld <= vld;
      end
   end

endmodule

// File: rtl/mux_arbiter_rr.sv
// Two-requester round-robin arbiter driving a shared registered 2:1 mux.
// Define MUX_ARB_LOCK_EN to add the lock input that suppresses hold-limit preemption.
module mux_arbiter_rr
   import mux_arb_pkg::*;
#(
   parameter int W        = 8,
   parameter int MAX_HOLD = MAX_HOLD_DEF,
   parameter int CW       = CW_DEF
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         req0,
   input  logic         req1,
`ifdef MUX_ARB_LOCK_EN
   input  logic         lock,
`endif
   input  logic [W-1:0] d0,
   input  logic [W-1:0] d1,
   output logic         gnt0,
   output logic         gnt1,
   output logic         s,
   output logic [W-1:0] z,
   output logic         z_vld
);

   localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);

   state_t        state;
   state_t        state_nxt;
   logic          last;
   logic [CW-1:0] hold_cnt;
   logic          own_req;
   logic          other_req;
   logic          lock_act;
   logic          preempt;

`ifdef MUX_ARB_LOCK_EN
   assign lock_act = lock;
`else
   assign lock_act = 1'b0;
`endif

   always_comb begin
      // NOTE: defaults first so no path leaves these unassigned (no latch).
      own_req   = 1'b0;
      other_req = 1'b0;
      case (state)
         G0: begin own_req = req0; other_req = req1; end
         G1: begin own_req = req1; other_req = req0; end
         default: ;
      endcase
   end

   assign preempt   = own_req && other_req && (hold_cnt == HOLD_LAST) && !lock_act;
   assign state_nxt = next_state(state, req0, req1, last, preempt);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         gnt0     <= 1'b0;
         gnt1     <= 1'b0;
         s        <= 1'b0;
         last     <= 1'b1;
         hold_cnt <= '0;
      end else begin
         state <= state_nxt;
         gnt0  <= (state_nxt == G0);
         gnt1  <= (state_nxt == G1);
         // select holds through IDLE so the registered output does not glitch
         if (state_nxt == G0)      s <= 1'b0;
         else if (state_nxt == G1) s <= 1'b1;
         if (state_nxt != state && state_nxt != IDLE)
            last <= (state_nxt == G1);
         if (state_nxt != state || !other_req)
            hold_cnt <= '0;
         else if (!lock_act && hold_cnt != HOLD_LAST)
            hold_cnt <= hold_cnt + CW'(1);
      end
   end

   mux_reg_stage #(.W(W)) u_stage (
      .clk   (clk),
      .rst_n (rst_n),
      .sel   (s),
      .a     (d0),
      .b     (d1),
      .vld   (gnt0 | gnt1),
      .z     (z),
      .z_vld (z_vld)
   );

endmodule

// File: tb/tb_mux_arbiter_rr.sv
// Directed scoreboard bench for mux_arbiter_rr; expectations queued before each edge.
module tb_mux_arbiter_rr;

   typedef struct packed {
      logic       g0;
      logic       g1;
      logic       s;
      logic [7:0] z;
      logic       v;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       req0, req1, lock;
   logic [7:0] d0, d1;
   logic       gnt0, gnt1, s, z_vld;
   logic [7:0] z;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   mux_arbiter_rr #(.W(8), .MAX_HOLD(8), .CW(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .req0  (req0),
      .req1  (req1),
`ifdef MUX_ARB_LOCK_EN
      .lock  (lock),
`endif
      .d0    (d0),
      .d1    (d1),
      .gnt0  (gnt0),
      .gnt1  (gnt1),
      .s     (s),
      .z     (z),
      .z_vld (z_vld)
   );

   task automatic push(input logic g0, input logic g1, input logic sv,
                       input logic [7:0] zv, input logic v);
      exp_t e;
      e = {g0, g1, sv, zv, v};
      sb.push_back(e);
   endtask

   task automatic tick(input string tag);
      exp_t e, a;
      @(posedge clk);
      #1;
      checks++;
      if (sb.size() == 0) begin
         errors++;
         $error("FAIL %s: scoreboard empty", tag);
      end else begin
         e = sb.pop_front();
         a = {gnt0, gnt1, s, z, z_vld};
         assert (a === e) else begin
            errors++;
            $error("FAIL %s: got g0=%b g1=%b s=%b z=%h v=%b, expected g0=%b g1=%b s=%b z=%h v=%b",
                   tag, a.g0, a.g1, a.s, a.z, a.v, e.g0, e.g1, e.s, e.z, e.v);
         end
      end
   endtask

   task automatic check_zero(input string tag);
      exp_t a;
      a = {gnt0, gnt1, s, z, z_vld};
      checks++;
      assert (a === 12'h000) else begin
         errors++;
         $error("FAIL %s: got g0=%b g1=%b s=%b z=%h v=%b, expected all zero",
                tag, gnt0, gnt1, s, z, z_vld);
      end
   endtask

   task automatic do_reset();
      req0  = 1'b0;
      req1  = 1'b0;
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0;
      req0  = 1'b0;
      req1  = 1'b0;
      lock  = 1'b0;
      d0    = 8'h00;
      d1    = 8'h00;
      #12;
      check_zero("reset");
      rst_n = 1'b1;

      // single request from requester 0
      req0 = 1'b1; d0 = 8'hA5; d1 = 8'h3C;
      push(1, 0, 0, 8'hA5, 0); tick("r0_grant");
      push(1, 0, 0, 8'hA5, 1); tick("r0_data");
      req0 = 1'b0;
      push(0, 0, 0, 8'hA5, 1); tick("r0_release");
      push(0, 0, 0, 8'hA5, 0); tick("r0_idle");

      // tie after requester 0 owned: requester 1 wins
      req0 = 1'b1; req1 = 1'b1;
      push(0, 1, 1, 8'hA5, 0); tick("tie_g1");
      push(0, 1, 1, 8'h3C, 1); tick("tie_g1_data");
      req0 = 1'b0; req1 = 1'b0;
      push(0, 0, 1, 8'h3C, 1); tick("tie_release");
      push(0, 0, 1, 8'h3C, 0); tick("tie_idle");

      // tie after reset: requester 0 first, then direct handover
      do_reset();
      req0 = 1'b1; req1 = 1'b1; d0 = 8'h11; d1 = 8'h22;
      push(1, 0, 0, 8'h11, 0); tick("tie_rst_g0");
      push(1, 0, 0, 8'h11, 1); tick("tie_rst_data");
      req0 = 1'b0;
      push(0, 1, 1, 8'h11, 1); tick("handover");
      push(0, 1, 1, 8'h22, 1); tick("handover_data");

      // both held: eight-cycle alternation
      do_reset();
      req0 = 1'b1; req1 = 1'b1;
      for (int k = 0; k < 32; k++) begin
         logic own, prev;
         own  = ((k / 8) % 2) == 1;
         prev = (k == 0) ? 1'b0 : (((k - 1) / 8) % 2) == 1;
         push(!own, own, own, prev ? 8'h22 : 8'h11, k > 0);
         tick($sformatf("alt%0d", k));
      end

      // drop everything: select stays at 1
      req0 = 1'b0; req1 = 1'b0; d1 = 8'h55;
      push(0, 0, 1, 8'h55, 1); tick("drop_all");
      push(0, 0, 1, 8'h55, 0); tick("idle_hold_s");

      // asynchronous reset in the middle of G1
      req1 = 1'b1;
      push(0, 1, 1, 8'h55, 0); tick("g1_again");
      rst_n = 1'b0;
      #1;
      check_zero("async_reset");
      #2;
      req1  = 1'b0;
      rst_n = 1'b1;

`ifdef MUX_ARB_LOCK_EN
      do_reset();
      req0 = 1'b1; req1 = 1'b1; lock = 1'b1;
      for (int k = 0; k < 24; k++) begin
         push(1, 0, 0, 8'h11, k > 0);
         tick($sformatf("lock%0d", k));
      end
      lock = 1'b0;
      for (int k = 0; k < 8; k++) begin
         push(k == 7 ? 1'b0 : 1'b1, k == 7, k == 7, 8'h11, 1);
         tick($sformatf("unlock%0d", k));
      end
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
